// File: rtl/key_conditioner_if.sv
// key_conditioner_if: pushbutton/switch inputs and conditioned game-control outputs
//   KEY[3:0] raw active-low buttons, SWraw[9:0] raw switches (driven by master)
//   select1/select2/userquit/badSelect one-cycle pulses, inGameOn level,
//   SW debounced switches, swOneHot debounced SW has exactly one bit set (driven by slave)
interface key_conditioner_if;
  logic [3:0] KEY;
  logic [9:0] SWraw;
  logic       select1;
  logic       select2;
  logic       userquit;
  logic       inGameOn;
  logic [9:0] SW;
  logic       swOneHot;
  logic       badSelect;
  modport master(output KEY, SWraw, input select1, select2, userquit, inGameOn, SW, swOneHot, badSelect);
  modport slave(input KEY, SWraw, output select1, select2, userquit, inGameOn, SW, swOneHot, badSelect);
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces KEY/SWraw and turns presses into game-control pulses
//   CLOCK_50 sole clock, reset synchronous active-high
//   bus.slave: KEY/SWraw in; select1, select2, userquit, badSelect, inGameOn, SW, swOneHot out
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic CLOCK_50,
  input logic reset,
  key_conditioner_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [3:0] key_s1, key_s2, key_deb, key_dly, press;
  logic [CW-1:0] key_cnt [4];
  logic [9:0] sw_s1, sw_s2, sw_last, sw_deb;
  logic [CW-1:0] sw_cnt;
  logic in_game, one_hot, quit, ok;
  logic s1_q, s2_q, quit_q, bad_q;
  logic s1_n, s2_n, bad_n, game_n;
  // a press is the debounced level falling, seen one cycle after the update
  assign press = key_dly & ~key_deb;
  assign quit = press[2];
  assign one_hot = ($countones(sw_deb) == 1);
  assign ok = in_game & one_hot;
  assign s1_n = ~quit & press[0] & ok;
  assign s2_n = ~quit & press[1] & ~press[0] & ok;
  assign bad_n = ~quit & in_game & (press[0] | press[1]) & (~one_hot | (press[0] & press[1]));
  assign game_n = quit ? 1'b0 : (press[3] | in_game);
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_s1 <= '1;
      key_s2 <= '1;
      key_deb <= '1;
      key_dly <= '1;
      for (int i = 0; i < 4; i++) key_cnt[i] <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      sw_last <= '0;
      sw_deb <= '0;
      sw_cnt <= '0;
      in_game <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      quit_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      key_s1 <= bus.KEY;
      key_s2 <= key_s1;
      key_dly <= key_deb;
      for (int i = 0; i < 4; i++) begin
        if (key_s2[i] == key_deb[i]) key_cnt[i] <= '0;
        else if (key_cnt[i] == LAST) begin
          key_deb[i] <= key_s2[i];
          key_cnt[i] <= '0;
        end else key_cnt[i] <= key_cnt[i] + 1'b1;
      end
      sw_s1 <= bus.SWraw;
      sw_s2 <= sw_s1;
      sw_last <= sw_s2;
      // any movement of the synchronized vector restarts the shared count
      if (sw_s2 != sw_last || sw_s2 == sw_deb) sw_cnt <= '0;
      else if (sw_cnt == LAST) begin
        sw_deb <= sw_s2;
        sw_cnt <= '0;
      end else sw_cnt <= sw_cnt + 1'b1;
      in_game <= game_n;
      s1_q <= s1_n;
      s2_q <= s2_n;
      quit_q <= quit;
      bad_q <= bad_n;
    end
  end
  assign bus.select1 = s1_q;
  assign bus.select2 = s2_q;
  assign bus.userquit = quit_q;
  assign bus.badSelect = bad_q;
  assign bus.inGameOn = in_game;
  assign bus.SW = sw_deb;
  assign bus.swOneHot = one_hot;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed self-checking bench for key_conditioner with DEBOUNCE_CYCLES=4
module tb_key_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  key_conditioner_if bus();
  key_conditioner #(.DEBOUNCE_CYCLES(4)) dut (.CLOCK_50(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int passes = 0, total = 0, edge_no = 0;
  int n_s1, n_s2, n_q, n_bad, e_s1, e_s2, e_q, e_bad;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic clr();
    edge_no = 0;
    n_s1 = 0; n_s2 = 0; n_q = 0; n_bad = 0;
    e_s1 = -1; e_s2 = -1; e_q = -1; e_bad = -1;
  endtask
  // advance n clocks, sampling on the falling edge and tallying pulses
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      edge_no++;
      if (bus.select1) begin n_s1++; e_s1 = edge_no; end
      if (bus.select2) begin n_s2++; e_s2 = edge_no; end
      if (bus.userquit) begin n_q++; e_q = edge_no; end
      if (bus.badSelect) begin n_bad++; e_bad = edge_no; end
    end
  endtask
  initial begin
    bus.KEY = 4'hF;
    bus.SWraw = 10'h000;
    clr();
    cyc(2);
    reset = 1'b0;
    chk("rst_game", bus.inGameOn, 0);
    chk("rst_sw", bus.SW, 0);
    chk("rst_onehot", bus.swOneHot, 0);
    chk("rst_pulses", {bus.select1, bus.select2, bus.userquit, bus.badSelect}, 0);
    // start press: inGameOn rises on edge 7
    bus.KEY[3] = 1'b0;
    clr();
    cyc(6);
    chk("start_e6", bus.inGameOn, 0);
    cyc(1);
    chk("start_e7", bus.inGameOn, 1);
    bus.KEY[3] = 1'b1;
    cyc(12);
    chk("start_hold", bus.inGameOn, 1);
    // clean select1
    bus.SWraw = 10'h004;
    cyc(10);
    chk("sw_004", bus.SW, 10'h004);
    chk("onehot_004", bus.swOneHot, 1);
    bus.KEY[0] = 1'b0;
    clr();
    cyc(20);
    chk("s1_count", n_s1, 1);
    chk("s1_edge", e_s1, 7);
    chk("s1_nobad", n_bad + n_s2 + n_q, 0);
    bus.KEY[0] = 1'b1;
    clr();
    cyc(12);
    chk("release_quiet", n_s1 + n_s2 + n_q + n_bad, 0);
    // bouncing KEY[1]
    clr();
    for (int i = 0; i < 6; i++) begin
      bus.KEY[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc(2);
    end
    chk("bounce_quiet", n_s1 + n_s2 + n_q + n_bad, 0);
    bus.KEY[1] = 1'b0;
    clr();
    cyc(20);
    chk("s2_count", n_s2, 1);
    chk("s2_edge", e_s2, 7);
    bus.KEY[1] = 1'b1;
    cyc(12);
    // reject with two switches up
    bus.SWraw = 10'h003;
    cyc(10);
    chk("sw_003", bus.SW, 10'h003);
    chk("onehot_003", bus.swOneHot, 0);
    bus.KEY[0] = 1'b0;
    clr();
    cyc(12);
    chk("rej_bad", n_bad, 1);
    chk("rej_bad_edge", e_bad, 7);
    chk("rej_s1", n_s1, 0);
    bus.KEY[0] = 1'b1;
    cyc(12);
    // quit and start together
    bus.KEY[3:2] = 2'b00;
    clr();
    cyc(6);
    chk("prio_e6_game", bus.inGameOn, 1);
    cyc(1);
    chk("prio_e7_quit", bus.userquit, 1);
    chk("prio_e7_game", bus.inGameOn, 0);
    cyc(10);
    chk("prio_game_stays", bus.inGameOn, 0);
    chk("prio_quit_count", n_q, 1);
    bus.KEY[3:2] = 2'b11;
    cyc(12);
    // select while out of game: silent
    bus.KEY[0] = 1'b0;
    clr();
    cyc(12);
    chk("idle_silent", n_s1 + n_s2 + n_q + n_bad, 0);
    bus.KEY[0] = 1'b1;
    cyc(12);
    // reset during a debounce
    bus.KEY[0] = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    bus.KEY[0] = 1'b1;
    chk("midrst_sw", bus.SW, 0);
    chk("midrst_game", bus.inGameOn, 0);
    clr();
    cyc(15);
    chk("midrst_quiet", n_s1 + n_s2 + n_q + n_bad, 0);
    chk("midrst_sw_back", bus.SW, 10'h003);
    // same-cycle selects in game
    bus.KEY[3] = 1'b0;
    cyc(12);
    bus.KEY[3] = 1'b1;
    chk("regame", bus.inGameOn, 1);
    bus.SWraw = 10'h001;
    cyc(12);
    chk("onehot_001", bus.swOneHot, 1);
    bus.KEY[1:0] = 2'b00;
    clr();
    cyc(20);
    chk("dual_s1", n_s1, 1);
    chk("dual_bad", n_bad, 1);
    chk("dual_s2", n_s2, 0);
    chk("dual_edges", {e_s1[7:0], e_bad[7:0]}, 16'h0707);
    bus.KEY[1:0] = 2'b11;
    cyc(12);
    // key held low across reset release
    bus.KEY[2] = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    clr();
    cyc(20);
    chk("held_quit_count", n_q, 1);
    chk("held_quit_edge", e_q, 7);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), the number of consecutive stable cycles required to accept an input change; legal range 2..2^24.
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port KEY  input  4  raw active-low pushbuttons, asynchronous to CLOCK_50: [0] select1, [1] select2, [2] quit, [3] start.
REQ-005 SHALL have port SWraw  input  10  raw slide switches, asynchronous.
REQ-006 SHALL have port select1  output  1  one-cycle pulse: accepted first-tile select.
REQ-007 SHALL have port select2  output  1  one-cycle pulse: accepted second-tile select.
REQ-008 SHALL have port userquit  output  1  one-cycle pulse: quit.
REQ-009 SHALL have port inGameOn  output  1  level: game session active.
REQ-010 SHALL have port SW  output  10  debounced switch vector.
REQ-011 SHALL have port swOneHot  output  1  level: debounced SW has exactly one bit set.
REQ-012 SHALL have port badSelect  output  1  one-cycle pulse: a select press was rejected.

Function
REQ-013 SHALL pass each KEY bit and the SWraw vector through a two-flop synchronizer before any other use.
REQ-014 SHALL keep, per KEY bit, a debounced state and a counter; the counter increments each cycle the synchronized bit differs from the debounced state and clears to 0 on any cycle they agree.
REQ-015 SHALL update the debounced state and clear the counter when the counter equals DEBOUNCE_CYCLES-1 while a mismatch persists.
REQ-016 SHALL debounce SWraw as one 10-bit vector with one shared counter; any change of the synchronized vector during counting restarts the count from 0.
REQ-017 SHALL detect a press as a debounced KEY bit transitioning 1->0; release (0->1) generates no output.
REQ-018 SHALL register all pulses so that each is high for exactly one cycle, starting DEBOUNCE_CYCLES+3 rising edges after a clean raw edge.
REQ-019 SHALL generate at most one pulse per press regardless of hold time.
REQ-020 SHALL emit select1/select2 only when inGameOn=1 and swOneHot=1 in the cycle the press is detected; otherwise it SHALL pulse badSelect instead (no pulse if inGameOn=0).
REQ-021 SHALL, when KEY[0] and KEY[1] presses are detected in the same cycle, emit select1 only and pulse badSelect.
REQ-022 SHALL set inGameOn on a start press when inGameOn=0; a start press with inGameOn=1 SHALL be ignored.
REQ-023 SHALL, on a quit press, pulse userquit and clear inGameOn in the same cycle, regardless of inGameOn.
REQ-024 SHALL give quit priority: quit and start detected in the same cycle leave inGameOn=0; any select in that cycle SHALL be suppressed without badSelect.
REQ-025 SHALL compute swOneHot combinationally from the debounced SW only (popcount == 1).
REQ-026 SHALL size each counter to ceil(log2(DEBOUNCE_CYCLES)) bits; counters never wrap.

Reset
REQ-027 SHALL, while reset=1 at a clock edge, set synchronizers and KEY debounced states to 1 (released), SW debounced state and synchronizers to 0, all counters to 0, inGameOn=0, and all pulses to 0.
REQ-028 SHALL, after reset deasserts with a key already held low, accept that press after the normal debounce interval (one pulse).
REQ-029 SHALL abandon any in-progress count when reset asserts mid-debounce; no pulse results from pre-reset activity.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Clean press: reset, start pressed and held -> inGameOn=1 at edge 7; then SWraw=10'h004, KEY[0] held low 20 cycles -> SW=10'h004, swOneHot=1, single select1 pulse 7 edges after press, nothing on release.
REQ-031 Bounce: KEY[1] toggles every 2 cycles for 12 cycles, then held low -> no pulse during toggling; exactly one select2 pulse 7 edges after the final edge.
REQ-032 Reject: inGameOn=1, SWraw=10'h003, press KEY[0] -> swOneHot=0, badSelect pulse, select1 stays 0; repeat with inGameOn=0 -> no outputs at all.
REQ-033 Priority: KEY[2] and KEY[3] pressed on the same edge with inGameOn=1 -> userquit pulse, inGameOn=0 the following cycle and stays 0.
REQ-034 Reset mid-operation: KEY[0] low for 3 cycles, reset for 1 cycle, KEY[0] released -> all outputs 0, no pulse thereafter.
REQ-035 Same-cycle selects: KEY[0] and KEY[1] pressed together with inGameOn=1, SWraw=10'h001 -> one select1 pulse plus one badSelect pulse, select2 remains 0.
